// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader fed from a byte stream (optional IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
    parameter int IMEM_SIZE       = 1024,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] MAX_WORDS = 17'(IMEM_SIZE / 4);
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << IMEM_ADDR_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic [15:0] len_next;
    logic [31:0] addr_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign last_word = (word_cnt + 16'd1) == len;
    assign len_next  = {len[15:8], rx_data};
    assign addr_full = {14'd0, word_cnt, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else if ({1'b0, len_next} > MAX_WORDS) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
`endif
            S_DONE: done = 1'b1;
            S_ERR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Word assembly: first three bytes park in partial, the fourth completes the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            imem_we    <= 1'b0;
            imem_waddr <= 32'd0;
            imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                word_cnt <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_HI: len[15:8] <= rx_data;
                    S_LEN_LO: len[7:0]  <= rx_data;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {partial, rx_data};
                            imem_waddr <= addr_full & ADDR_MASK;
                            word_cnt   <= word_cnt + 16'd1;
                        end else begin
                            partial <= {partial[15:0], rx_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_done[$];
    int          hold_drop = 0;
    logic        hold_watch = 1'b0;
    logic [7:0]  img[$];

    imem_loader #(.IMEM_SIZE(1024), .IMEM_ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_waddr);
            log_data.push_back(imem_wdata);
            log_done.push_back(done);
        end
        if (hold_watch && !done && !err && (!busy || !cpu_hold)) hold_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (rx_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("rx_timeout", {31'd0, rx_ready}, 32'd1);
        if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic stream_off();
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    // Sends img[first..last]; with the checksum build the trailing XOR byte follows when add_csum is set.
    task automatic send_range(input int first, input int last, input int gap, input bit add_csum);
        logic [7:0] x;
        for (int i = first; i <= last; i++) send_byte(img[i], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (add_csum) begin
            x = 8'h00;
            for (int i = 2; i < img.size(); i++) x = x ^ img[i];
            send_byte(x, gap);
        end
`else
        x = 8'h00;
        if (add_csum && x != 8'h00) $display("unexpected");
`endif
    endtask

    task automatic set_basic();
        img = '{8'h00, 8'h02, 8'h3c, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3d, 8'h00, 8'h14};
    endtask

    task automatic check_basic_writes(input string tag, input int base);
        chk({tag, "_nwr"}, log_addr.size() - base, 2);
        if (log_addr.size() - base == 2) begin
            chk({tag, "_a0"}, log_addr[base], 32'h0);
            chk({tag, "_d0"}, log_data[base], 32'h3c011001);
            chk({tag, "_a1"}, log_addr[base+1], 32'h4);
            chk({tag, "_d1"}, log_data[base+1], 32'h343d0014);
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk({tag, "_done_at_wr"}, {31'd0, log_done[base+1]}, 32'd1);
`endif
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    initial begin
        int base;
        int hb;

        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_waddr", imem_waddr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic load with continuous valid
        set_basic();
        base = log_addr.size();
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        send_range(0, img.size() - 1, 0, 1'b1);
        stream_off();
        check_basic_writes("basic", base);

        // stalled stream
        base = log_addr.size();
        hb = hold_drop;
        pulse_start();
        hold_watch = 1'b1;
        send_range(0, img.size() - 1, 3, 1'b1);
        stream_off();
        hold_watch = 1'b0;
        check_basic_writes("stall", base);
        chk("stall_hold_drop", hold_drop - hb, 0);

        // empty image
        img = '{8'h00, 8'h00};
        base = log_addr.size();
        pulse_start();
        send_range(0, 1, 0, 1'b1);
        stream_off();
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_nwr", log_addr.size() - base, 0);

        // oversize image
        img = '{8'h01, 8'h01};
        base = log_addr.size();
        pulse_start();
        send_range(0, 1, 0, 1'b0);
        stream_off();
        chk("over_err", {31'd0, err}, 32'd1);
        chk("over_hold", {31'd0, cpu_hold}, 32'd1);
        chk("over_ready", {31'd0, rx_ready}, 32'd0);
        chk("over_busy", {31'd0, busy}, 32'd0);
        chk("over_nwr", log_addr.size() - base, 0);

        set_basic();
        base = log_addr.size();
        pulse_start();
        chk("err_cleared", {31'd0, err}, 32'd0);
        send_range(0, img.size() - 1, 0, 1'b1);
        stream_off();
        check_basic_writes("after_err", base);
        chk("after_err_err", {31'd0, err}, 32'd0);

        // reset mid-load after 6 bytes
        base = log_addr.size();
        pulse_start();
        send_range(0, 5, 0, 1'b0);
        stream_off();
        chk("midrst_nwr", log_addr.size() - base, 1);
        if (log_addr.size() - base == 1) begin
            chk("midrst_a0", log_addr[base], 32'h0);
            chk("midrst_d0", log_data[base], 32'h3c011001);
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("midrst_ready", {31'd0, rx_ready}, 32'd0);
        chk("midrst_we", {31'd0, imem_we}, 32'd0);
        chk("midrst_waddr", imem_waddr, 32'd0);
        chk("midrst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base = log_addr.size();
        pulse_start();
        send_range(0, img.size() - 1, 0, 1'b1);
        stream_off();
        check_basic_writes("post_rst", base);

        // start while busy is ignored
        base = log_addr.size();
        pulse_start();
        send_range(0, 3, 1, 1'b0);
        pulse_start();
        chk("busy_start_busy", {31'd0, busy}, 32'd1);
        send_range(4, img.size() - 1, 0, 1'b1);
        stream_off();
        check_basic_writes("busy_start", base);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0c};
        base = log_addr.size();
        pulse_start();
        send_range(0, 5, 0, 1'b0);
        send_byte(8'h0c, 0);
        stream_off();
        chk("csum_ok_done", {31'd0, done}, 32'd1);
        chk("csum_ok_nwr", log_addr.size() - base, 1);
        if (log_addr.size() - base == 1) begin
            chk("csum_ok_a", log_addr[base], 32'h0);
            chk("csum_ok_d", log_data[base], 32'h0000000c);
        end

        base = log_addr.size();
        pulse_start();
        send_range(0, 5, 0, 1'b0);
        send_byte(8'h0d, 0);
        stream_off();
        chk("csum_bad_err", {31'd0, err}, 32'd1);
        chk("csum_bad_done", {31'd0, done}, 32'd0);
        chk("csum_bad_nwr", log_addr.size() - base, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
